// File: rtl/counter_pkg.sv
// Shared definitions for the parity step counter: mode encodings and
// small bit-level helpers used by both the next-value logic and the top.
package counter_pkg;

  // Counting modes as driven on the MODE input
  typedef enum logic [1:0] {
    MODE_ALL  = 2'b00,
    MODE_EVEN = 2'b01,
    MODE_ODD  = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  // Bit 0 of a loaded value: forced to the parity class of the mode, if any
  function automatic logic load_bit0(mode_e m, logic b0);
    logic r;
    case (m)
      MODE_EVEN: r = 1'b0;
      MODE_ODD:  r = 1'b1;
      MODE_ALL:  r = b0;
      MODE_HOLD: r = b0;
      default:   r = b0;
    endcase
    return r;
  endfunction

  // True when the current value already sits in the mode's parity class,
  // i.e. a full double step is taken instead of an alignment step
  function automatic logic parity_match(mode_e m, logic b0);
    logic r;
    case (m)
      MODE_EVEN: r = ~b0;
      MODE_ODD:  r = b0;
      MODE_ALL:  r = 1'b0;
      MODE_HOLD: r = 1'b0;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/parity_step_next.sv
// Combinational next-value and wrap detection for one counter step.
// The step is computed one bit wider than the counter so the extra bit
// is the carry (counting up) or the borrow (counting down), which is
// exactly the wrap condition, alignment steps included.
module parity_step_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap
);

  localparam logic [WIDTH:0] STEP1 = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] STEP2 = {{(WIDTH-1){1'b0}}, 2'b10};

  logic [WIDTH:0] step_amt;
  logic [WIDTH:0] ext_res;
  logic           active;

  // Choose step size from mode and current parity, then add or subtract
  always_comb begin
    step_amt = STEP1;
    ext_res  = {1'b0, q};
    active   = 1'b0;
    next_q   = q;
    wrap     = 1'b0;
    case (mode)
      MODE_ALL: begin
        step_amt = STEP1;
        active   = 1'b1;
      end
      MODE_EVEN, MODE_ODD: begin
        step_amt = parity_match(mode, q[0]) ? STEP2 : STEP1;
        active   = 1'b1;
      end
      MODE_HOLD: begin
        step_amt = STEP1;
        active   = 1'b0;
      end
      default: begin
        step_amt = STEP1;
        active   = 1'b0;
      end
    endcase
    if (active) begin
      if (dir) begin
        ext_res = {1'b0, q} + step_amt;
      end else begin
        ext_res = {1'b0, q} - step_amt;
      end
      next_q = ext_res[WIDTH-1:0];
      wrap   = ext_res[WIDTH];
    end else begin
      ext_res = {1'b0, q};
      next_q  = q;
      wrap    = 1'b0;
    end
  end

endmodule

// File: rtl/parity_step_counter.sv
// Up/down counter stepping through all, even-only or odd-only values,
// with a synchronous load, a one-cycle terminal-count pulse on each wrap
// and a saturating count of wraps. All outputs are registered.
module parity_step_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              EN,
  input  logic              DIR,
  input  logic [1:0]        MODE,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VAL,
  output logic [WIDTH-1:0]  Q,
  output logic              TC,
  output logic [WRAP_W-1:0] WRAPS
);

  localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAPS_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  mode_e             mode_s;
  logic [WIDTH-1:0]  next_q_s;
  logic              wrap_s;

  logic [WIDTH-1:0]  q_q, q_d;
  logic              tc_q, tc_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;

  assign mode_s = mode_e'(MODE);

  parity_step_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q      (q_q),
    .dir    (DIR),
    .mode   (mode_s),
    .next_q (next_q_s),
    .wrap   (wrap_s)
  );

  // Next register state: load beats step beats hold; TC only follows a wrap
  always_comb begin
    q_d     = q_q;
    tc_d    = 1'b0;
    wraps_d = wraps_q;
    if (LOAD) begin
      q_d     = {LOAD_VAL[WIDTH-1:1], load_bit0(mode_s, LOAD_VAL[0])};
      tc_d    = 1'b0;
      wraps_d = wraps_q;
    end else if (EN) begin
      // In hold mode the step logic returns the current value with no wrap
      q_d  = next_q_s;
      tc_d = wrap_s;
      if (wrap_s && (wraps_q != WRAPS_MAX)) begin
        wraps_d = wraps_q + WRAPS_ONE;
      end else begin
        wraps_d = wraps_q;
      end
    end else begin
      q_d     = q_q;
      tc_d    = 1'b0;
      wraps_d = wraps_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q     <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      wraps_q <= {WRAP_W{1'b0}};
    end else begin
      q_q     <= q_d;
      tc_q    <= tc_d;
      wraps_q <= wraps_d;
    end
  end

  assign Q     = q_q;
  assign TC    = tc_q;
  assign WRAPS = wraps_q;

endmodule

// File: tb/tb_parity_step_counter.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=2 counter share one stimulus
// stream and are both compared every cycle against an integer model of
// the counting rules. Directed scenarios are followed by random stimulus.
module tb_parity_step_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;

  logic [3:0] q4;
  logic       tc4;
  logic [7:0] wr4;
  logic [1:0] q2;
  logic       tc2;
  logic [7:0] wr2;

  int checks   = 0;
  int failures = 0;

  // model state per instance: index 0 -> WIDTH 4, index 1 -> WIDTH 2
  int m_q  [2];
  int m_tc [2];
  int m_wr [2];
  int m_w  [2] = '{4, 2};

  int exp030 [9] = '{2, 4, 6, 8, 10, 12, 14, 0, 2};

  parity_step_counter #(.WIDTH(4), .WRAP_W(8)) dut4 (
    .CLK      (clk),
    .RST_N    (rst_n),
    .EN       (en),
    .DIR      (dir),
    .MODE     (mode),
    .LOAD     (load),
    .LOAD_VAL (load_val),
    .Q        (q4),
    .TC       (tc4),
    .WRAPS    (wr4)
  );

  parity_step_counter #(.WIDTH(2), .WRAP_W(8)) dut2 (
    .CLK      (clk),
    .RST_N    (rst_n),
    .EN       (en),
    .DIR      (dir),
    .MODE     (mode),
    .LOAD     (load),
    .LOAD_VAL (load_val[1:0]),
    .Q        (q2),
    .TC       (tc2),
    .WRAPS    (wr2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int modv, lv, delta, raw;
      modv = 1 << m_w[i];
      if (!rst_n) begin
        m_q[i] = 0; m_tc[i] = 0; m_wr[i] = 0;
      end else if (load) begin
        lv = int'(load_val) % modv;
        if (mode == 2'd1) lv = lv - (lv % 2);
        if (mode == 2'd2 && (lv % 2) == 0) lv = lv + 1;
        m_q[i] = lv; m_tc[i] = 0;
      end else if (en && mode != 2'd3) begin
        if (mode == 2'd0) delta = 1;
        else if ((mode == 2'd1) == ((m_q[i] % 2) == 0)) delta = 2;
        else delta = 1;
        raw = dir ? m_q[i] + delta : m_q[i] - delta;
        m_tc[i] = (raw > modv - 1 || raw < 0) ? 1 : 0;
        m_q[i]  = (raw + modv) % modv;
        if (m_tc[i] == 1 && m_wr[i] < 255) m_wr[i]++;
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  // One clock edge: update model, then sample both DUTs just after the edge
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("q4",  int'(q4),  m_q[0]);
    chk("tc4", int'(tc4), m_tc[0]);
    chk("wr4", int'(wr4), m_wr[0]);
    chk("q2",  int'(q2),  m_q[1]);
    chk("tc2", int'(tc2), m_tc[1]);
    chk("wr2", int'(wr2), m_wr[1]);
  endtask

  task automatic set_in(input logic r, input logic e, input logic d,
                        input logic [1:0] m, input logic l, input logic [3:0] v);
    rst_n = r; en = e; dir = d; mode = m; load = l; load_val = v;
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0);
    m_q = '{0, 0}; m_tc = '{0, 0}; m_wr = '{0, 0};
    #2;

    // reset for two edges
    cycle();
    cycle();
    chk("rst_q", int'(q4), 0);
    chk("rst_wr", int'(wr4), 0);

    // even counting up, wraps once
    set_in(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0);
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("seq_even_up", int'(q4), exp030[k]);
      chk("tc_even_up", int'(tc4), (exp030[k] == 0) ? 1 : 0);
    end
    chk("wraps_even_up", int'(wr4), 1);

    // odd counting down from reset: alignment wrap then normal wrap
    set_in(1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 4'd0);
    cycle();
    chk("odd_dn_first", int'(q4), 15);
    chk("odd_dn_tc", int'(tc4), 1);
    for (int k = 0; k < 8; k++) cycle();
    chk("odd_dn_wrap_q", int'(q4), 15);
    chk("odd_dn_wraps", int'(wr4), 2);

    // load with parity forcing
    set_in(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'd7);
    cycle();
    chk("load_even", int'(q4), 6);
    chk("load_tc", int'(tc4), 0);
    set_in(1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 4'd8);
    cycle();
    chk("load_odd", int'(q4), 9);

    // mode switch mid-count, then hold
    set_in(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'd6);
    cycle();
    set_in(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'd0);
    cycle();
    chk("switch_align", int'(q4), 7);
    cycle();
    cycle();
    chk("switch_odd", int'(q4), 11);
    set_in(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 4'd0);
    cycle();
    cycle();
    chk("hold_q", int'(q4), 11);
    chk("hold_tc", int'(tc4), 0);

    // reset overrides load and enable
    set_in(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd10);
    cycle();
    set_in(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 4'd5);
    cycle();
    chk("rst_ovr_q", int'(q4), 0);
    chk("rst_ovr_wr", int'(wr4), 0);

    // saturation of the wrap counter on the narrow instance
    set_in(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0);
    for (int k = 0; k < 520; k++) cycle();
    chk("sat_wr2", int'(wr2), 255);
    cycle();
    chk("sat_tc_pulse", int'(tc2) + int'(q2 == 2'd0), (q2 == 2'd0) ? 2 : 0);

    // random stimulus
    for (int k = 0; k < 1500; k++) begin
      set_in(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
             1'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0),
             4'($urandom));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_step_counter.md
PARITY_STEP_COUNTER -- requirements
Module: parity_step_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 Parameter WRAP_W, default 8, width of the wrap-event counter.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  step enable, one step per enabled rising edge.
REQ-006 DIR  input  1  direction: 1 up, 0 down.
REQ-007 MODE  input  2  00 all values (step 1); 01 even only (step 2); 10 odd only (step 2); 11 hold.
REQ-008 LOAD  input  1  synchronous load strobe.
REQ-009 LOAD_VAL  input  WIDTH  value to load.
REQ-010 Q  output  WIDTH  registered count value.
REQ-011 TC  output  1  registered terminal-count pulse, high one cycle per wrap.
REQ-012 WRAPS  output  WRAP_W  registered saturating count of wrap events.

Function
REQ-013 Priority per edge SHALL be: RST_N low > LOAD > EN step > hold.
REQ-014 LOAD SHALL set Q to LOAD_VAL with bit 0 forced 0 in MODE 01, forced 1 in MODE 10, unmodified in MODE 00 and 11; TC SHALL be 0 and WRAPS unchanged on a load edge.
REQ-015 MODE 00 step SHALL be Q+1 (up) / Q-1 (down), modulo 2^WIDTH.
REQ-016 MODE 01/10 step with Q parity matching mode SHALL be Q+2 / Q-2 modulo 2^WIDTH; even sequence 0,2,...,2^WIDTH-2,0; odd sequence 1,3,...,2^WIDTH-1,1.
REQ-017 MODE 01/10 step with Q parity mismatching mode (alignment step) SHALL be Q+1 / Q-1 modulo 2^WIDTH; alignment consumes that step.
REQ-018 A wrap SHALL be any step whose unbounded result is > 2^WIDTH-1 (up) or < 0 (down), including alignment steps.
REQ-019 TC SHALL be 1 in exactly the cycle after a wrapping step (coincident with the wrapped Q), else 0.
REQ-020 WRAPS SHALL increment by 1 on each wrap and saturate at 2^WRAP_W-1; cleared only by reset.
REQ-021 MODE 11 SHALL hold Q and WRAPS regardless of EN; TC SHALL be 0; LOAD still applies.
REQ-022 EN low SHALL hold Q and WRAPS; TC SHALL be 0.
REQ-023 MODE or DIR changes SHALL take effect on the next step edge with no extra latency.
REQ-024 Latency: all outputs change exactly one edge after the qualifying input sample.

Reset
REQ-025 RST_N low at a rising edge SHALL set Q=0, TC=0, WRAPS=0, overriding LOAD and EN.
REQ-026 Reset asserted mid-count SHALL discard any in-progress step; first step after release proceeds from Q=0 per current MODE/DIR.
REQ-027 No asynchronous reset path SHALL exist.

Structure
REQ-028 MODE encodings (ALL, EVEN, ODD, HOLD) SHALL be named constants in shared package counter_pkg.
REQ-029 Next-value and wrap-flag computation SHALL be one combinational sub-module parity_step_next (inputs Q, DIR, MODE; outputs next Q, wrap); registers, load, and WRAPS live in the top.

Verification (WIDTH=4, WRAP_W=8 unless noted)
REQ-030 Reset 2 cycles, then EN=1, MODE=01, DIR=1 for 9 edges -> Q 2,4,6,8,10,12,14,0,2; TC=1 only with Q=0; WRAPS=1.
REQ-031 From reset, MODE=10, DIR=0, EN=1 -> Q 15 (alignment wrap, TC=1, WRAPS=1), 13,11,...,1, 15 (TC=1, WRAPS=2).
REQ-032 MODE=01, LOAD=1, EN=1, LOAD_VAL=7 -> Q=6, TC=0; then MODE=10, LOAD_VAL=8 -> Q=9.
REQ-033 MODE=01 counting up at Q=6, switch MODE=10 -> Q=7, then 9, 11; switch MODE=11 with EN=1 -> Q holds 11, TC=0.
REQ-034 At Q=10, drive RST_N=0 with EN=1, LOAD=1, LOAD_VAL=5 -> next edge Q=0, TC=0, WRAPS=0.
REQ-035 WIDTH=2, MODE=01, DIR=1, EN=1 for 520 edges -> WRAPS reaches 255 and stays 255; TC still pulses every second edge.
